// File: rtl/fir_peak_detector.sv
// Windowed amplitude measurement on a filtered sample stream: per window of N valid samples
// reports signed max/min, unsigned peak-to-peak and a threshold flag.
module fir_peak_detector #(
   parameter int DATA_WIDTH   = 32,
   parameter int WINDOW_WIDTH = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enable,
   input  logic signed [DATA_WIDTH-1:0] data,
   input  logic                         data_valid,
   input  logic [WINDOW_WIDTH-1:0]      window_length,
   input  logic [DATA_WIDTH-1:0]        threshold,
   output logic signed [DATA_WIDTH-1:0] maximum,
   output logic signed [DATA_WIDTH-1:0] minimum,
   output logic [DATA_WIDTH:0]          peak_to_peak,
   output logic                         above_threshold,
   output logic                         result_valid
);

   typedef enum logic [1:0] {IDLE, FIRST, ACCUM} state_t;

   state_t                       state, next_state;
   logic [WINDOW_WIDTH-1:0]      len, counter, count_next, first_len;
   logic signed [DATA_WIDTH-1:0] run_max, run_min, new_max, new_min;
   logic [DATA_WIDTH:0]          diff;
   logic                         accept, done;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // A zero window length would never complete, so it behaves as a one-sample window.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      done       = 1'b0;
      new_max    = run_max;
      new_min    = run_min;
      count_next = counter;
      first_len  = (window_length == '0) ? WINDOW_WIDTH'(1) : window_length;
      if (!enable) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: next_state = FIRST;
            FIRST: begin
               if (data_valid) begin
                  accept     = 1'b1;
                  new_max    = data;
                  new_min    = data;
                  count_next = WINDOW_WIDTH'(1);
                  if (first_len == WINDOW_WIDTH'(1)) done = 1'b1;
                  else                               next_state = ACCUM;
               end
            end
            ACCUM: begin
               if (data_valid) begin
                  accept     = 1'b1;
                  new_max    = (data > run_max) ? data : run_max;
                  new_min    = (data < run_min) ? data : run_min;
                  count_next = counter + WINDOW_WIDTH'(1);
                  if (count_next == len) begin
                     done       = 1'b1;
                     next_state = FIRST;
                  end
               end
            end
            default: next_state = IDLE;
         endcase
      end
      diff = {new_max[DATA_WIDTH-1], new_max} - {new_min[DATA_WIDTH-1], new_min};
   end

   // Results are taken from the just-updated extremes so they land one clock after the last sample.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         len             <= '0;
         counter         <= '0;
         run_max         <= '0;
         run_min         <= '0;
         maximum         <= '0;
         minimum         <= '0;
         peak_to_peak    <= '0;
         above_threshold <= 1'b0;
         result_valid    <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (accept) begin
            run_max <= new_max;
            run_min <= new_min;
            counter <= count_next;
            if (state == FIRST) len <= first_len;
         end
         if (done) begin
            maximum         <= new_max;
            minimum         <= new_min;
            peak_to_peak    <= diff;
            above_threshold <= (diff >= {1'b0, threshold});
            result_valid    <= 1'b1;
         end
      end
   end

endmodule
